stepper_multiaxis: RTL and testbench

// - N-channel step/dir pulse generator. It is the parametrised successor of the two-channel

---
 rtl/stepper_pkg.sv | 25 ++
 rtl/stepper_channel.sv | 127 ++++++++++++
 rtl/stepper_multiaxis.sv | 72 +++++++
 tb/tb_stepper_multiaxis.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and helpers for the multi-axis step/dir generator.
package stepper_pkg;

  // Widest step count the helpers handle; callers sign-extend into and slice out of this.
  localparam int unsigned MaxCntW = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } ch_state_e;

  // Magnitude of a two's complement value; the most negative value maps to 2^(w-1).
  function automatic logic [MaxCntW-1:0] abs_val(input logic [MaxCntW-1:0] v);
    return v[MaxCntW-1] ? (~v + 64'd1) : v;
  endfunction

  // Re-applies a direction to a magnitude (neg = 1 gives -mag).
  function automatic logic [MaxCntW-1:0] apply_sign(input logic [MaxCntW-1:0] mag,
                                                    input logic               neg);
    return neg ? (~mag + 64'd1) : mag;
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One step/dir channel: direction setup delay, step pulse timing, remaining-step tracking and
// direction-aware endstop / global abort.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PER_W     = 32,
  parameter int unsigned DIR_SETUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] steps_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             abort_all_i,
  input  logic             endstop_min_i,
  input  logic             endstop_max_i,
  output logic             step_o,
  output logic             dir_o,
  output logic             running_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] steps_left_o
);

  localparam logic [PER_W-1:0] SetupLd = PER_W'((DIR_SETUP > 0) ? DIR_SETUP - 1 : 0);

  ch_state_e          state_q;
  logic [PER_W-1:0]   per_q;
  logic [PER_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   mag_q;
  logic               dir_q;
  logic               step_q;
  logic               aborted_q;

  logic               nonzero;
  logic               stop;
  logic [PER_W-1:0]   per_ld;
  logic [MaxCntW-1:0] mag_ext;
  logic [MaxCntW-1:0] left_ext;

  assign nonzero  = |steps_i;
  assign per_ld   = (period_i == '0) ? PER_W'(1) : period_i;
  assign mag_ext  = abs_val(MaxCntW'($signed(steps_i)));
  // Only the endstop ahead of the direction of travel can stop the channel.
  assign stop     = (state_q != StIdle) &&
                    (abort_all_i || (dir_q ? endstop_min_i : endstop_max_i));
  assign left_ext = apply_sign(MaxCntW'(mag_q), dir_q);

  assign step_o       = step_q;
  assign dir_o        = dir_q;
  assign running_o    = (state_q != StIdle);
  assign aborted_o    = aborted_q;
  assign steps_left_o = left_ext[CNT_W-1:0];

  // Channel FSM with registered step output and down-counters for setup and half-periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      per_q     <= PER_W'(1);
      cnt_q     <= '0;
      mag_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (load_i) begin
        dir_q     <= steps_i[CNT_W-1];
        mag_q     <= mag_ext[CNT_W-1:0];
        per_q     <= per_ld;
        aborted_q <= 1'b0;
        if (nonzero) begin
          if (DIR_SETUP == 0) begin
            state_q <= StHigh;
            step_q  <= 1'b1;
            cnt_q   <= per_ld - PER_W'(1);
          end else begin
            state_q <= StSetup;
            cnt_q   <= SetupLd;
          end
        end
      end
    end else if (stop) begin
      state_q   <= StIdle;
      step_q    <= 1'b0;
      aborted_q <= 1'b1;
      // A pulse already on the wire counts as a taken step.
      if (state_q == StHigh) mag_q <= mag_q - CNT_W'(1);
    end else begin
      case (state_q)
        StSetup: begin
          if (cnt_q == '0) begin
            state_q <= StHigh;
            step_q  <= 1'b1;
            cnt_q   <= per_q - PER_W'(1);
          end else begin
            cnt_q <= cnt_q - PER_W'(1);
          end
        end
        StHigh: begin
          if (cnt_q == '0) begin
            state_q <= StLow;
            step_q  <= 1'b0;
            cnt_q   <= per_q - PER_W'(1);
            mag_q   <= mag_q - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - PER_W'(1);
          end
        end
        StLow: begin
          if (cnt_q == '0) begin
            if (mag_q != '0) begin
              state_q <= StHigh;
              step_q  <= 1'b1;
              cnt_q   <= per_q - PER_W'(1);
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - PER_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/stepper_multiaxis.sv
// N-channel step/dir pulse generator: command accept, per-axis channels, busy/done reporting.
module stepper_multiaxis
  import stepper_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PER_W     = 32,
  parameter int unsigned DIR_SETUP = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_CH*CNT_W-1:0] steps_in,
  input  logic [NUM_CH*PER_W-1:0] period_in,
  input  logic                    enable,
  input  logic                    abort_all,
  input  logic [NUM_CH-1:0]       endstop_min,
  input  logic [NUM_CH-1:0]       endstop_max,
  output logic [NUM_CH-1:0]       step_out,
  output logic [NUM_CH-1:0]       dir_out,
  output logic                    en_n_out,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       aborted,
  output logic [NUM_CH*CNT_W-1:0] steps_left
);

  logic [NUM_CH-1:0] running;
  logic              accept;
  logic              was_busy_q;
  logic              done_q;

  // A command with every count zero would start nothing, so it is dropped entirely.
  assign accept   = start && !busy && (|steps_in);
  assign busy     = |running;
  assign done     = done_q;
  assign en_n_out = ~enable;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stepper_channel #(
      .CNT_W    (CNT_W),
      .PER_W    (PER_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (accept),
      .steps_i      (steps_in[g*CNT_W +: CNT_W]),
      .period_i     (period_in[g*PER_W +: PER_W]),
      .abort_all_i  (abort_all),
      .endstop_min_i(endstop_min[g]),
      .endstop_max_i(endstop_max[g]),
      .step_o       (step_out[g]),
      .dir_o        (dir_out[g]),
      .running_o    (running[g]),
      .aborted_o    (aborted[g]),
      .steps_left_o (steps_left[g*CNT_W +: CNT_W])
    );
  end

  // done pulses in the cycle after the last channel has returned to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      was_busy_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      was_busy_q <= busy;
      done_q     <= was_busy_q && !busy;
    end
  end

endmodule

// File: tb/tb_stepper_multiaxis.sv
// Directed bench for stepper_multiaxis (NUM_CH=4, CNT_W=32, PER_W=32, DIR_SETUP=8).
module tb_stepper_multiaxis;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] steps_in;
  logic [127:0] period_in;
  logic         enable;
  logic         abort_all;
  logic [3:0]   endstop_min;
  logic [3:0]   endstop_max;
  logic [3:0]   step_out;
  logic [3:0]   dir_out;
  logic         en_n_out;
  logic         busy;
  logic         done;
  logic [3:0]   aborted;
  logic [127:0] steps_left;

  int checks = 0;
  int errors = 0;

  stepper_multiaxis #(
    .NUM_CH   (4),
    .CNT_W    (32),
    .PER_W    (32),
    .DIR_SETUP(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .steps_in   (steps_in),
    .period_in  (period_in),
    .enable     (enable),
    .abort_all  (abort_all),
    .endstop_min(endstop_min),
    .endstop_max(endstop_max),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .en_n_out   (en_n_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Presents a command for one cycle; returns at the falling edge of the first cycle after accept.
  task automatic issue(input logic [127:0] s, input logic [127:0] p);
    @(negedge clk);
    steps_in  = s;
    period_in = p;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; enable = 1'b0; abort_all = 1'b0;
    endstop_min = '0; endstop_max = '0; steps_in = '0; period_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (step_out !== 4'b0 || dir_out !== 4'b0) begin
      errors++; $display("FAIL reset_step_dir: got %b/%b expected 0000/0000", step_out, dir_out);
    end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b aborted=%b expected 0 0 0000",
                         busy, done, aborted);
    end
    checks++; if (steps_left !== 128'd0) begin
      errors++; $display("FAIL reset_steps_left: got %h expected 0", steps_left);
    end
    rst_n = 1'b1;
    enable = 1'b1; #1;
    checks++; if (en_n_out !== 1'b0) begin
      errors++; $display("FAIL en_n_high: got %b expected 0", en_n_out);
    end
    enable = 1'b0; #1;
    checks++; if (en_n_out !== 1'b1) begin
      errors++; $display("FAIL en_n_low: got %b expected 1", en_n_out);
    end
    enable = 1'b1;
  endtask

  // {+3, -2, 0, 0}, P=2: ch0 high 9-10,13-14,17-18; ch1 high 9-10,13-14; done at 22.
  task automatic test_basic;
    logic e0, e1;
    issue(pack4(32'd3, 32'hFFFF_FFFE, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) @(negedge clk);
      e0 = (k >= 9 && k < 21 && ((k - 9) % 4) < 2);
      e1 = (k >= 9 && k < 17 && ((k - 9) % 4) < 2);
      checks++; if (step_out !== {2'b00, e1, e0}) begin
        errors++; $display("FAIL basic_step k=%0d: got %b expected %b", k, step_out, {2'b00, e1, e0});
      end
      checks++; if (busy !== (k <= 20)) begin
        errors++; $display("FAIL basic_busy k=%0d: got %b expected %b", k, busy, (k <= 20));
      end
      checks++; if (done !== (k == 22)) begin
        errors++; $display("FAIL basic_done k=%0d: got %b expected %b", k, done, (k == 22));
      end
      if (k == 11) begin
        checks++; if (steps_left[63:0] !== {32'hFFFF_FFFF, 32'd2}) begin
          errors++; $display("FAIL basic_left_k11: got %h expected ffffffff00000002",
                             steps_left[63:0]);
        end
      end
    end
    checks++; if (dir_out !== 4'b0010) begin
      errors++; $display("FAIL basic_dir: got %b expected 0010", dir_out);
    end
    checks++; if (steps_left !== 128'd0 || aborted !== 4'b0) begin
      errors++; $display("FAIL basic_end: got left=%h aborted=%b expected 0 0000",
                         steps_left, aborted);
    end
  endtask

  // ch0 +10, endstop_max raised during the LOW after pulse 4.
  task automatic test_endstop_low;
    logic prev;
    int   rises = 0;
    issue(pack4(32'd10, 32'd0, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    prev = step_out[0];
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (step_out[0] && !prev) rises++;
      prev = step_out[0];
      if (k == 24) begin
        checks++; if (step_out[0] !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL es_low_stop: got step=%b busy=%b done=%b expected 0 0 0",
                             step_out[0], busy, done);
        end
        checks++; if (aborted !== 4'b0001 || steps_left[31:0] !== 32'd6) begin
          errors++; $display("FAIL es_low_state: got aborted=%b left=%0d expected 0001 6",
                             aborted, steps_left[31:0]);
        end
        endstop_max = 4'b0000;
      end
      if (k == 25) begin
        checks++; if (done !== 1'b1) begin
          errors++; $display("FAIL es_low_done: got %b expected 1", done);
        end
      end
      if (k == 23) endstop_max = 4'b0001;
    end
    checks++; if (rises != 4 || aborted !== 4'b0001) begin
      errors++; $display("FAIL es_low_pulses: got %0d pulses aborted=%b expected 4 0001",
                         rises, aborted);
    end
  endtask

  // ch0 +10, endstop_max raised in the first HIGH cycle: the cut pulse counts as taken.
  task automatic test_endstop_cut;
    issue(pack4(32'd10, 32'd0, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 9) begin
        checks++; if (step_out[0] !== 1'b1) begin
          errors++; $display("FAIL es_cut_rise: got %b expected 1", step_out[0]);
        end
        endstop_max = 4'b0001;
      end
      if (k == 10) begin
        checks++;
        if (step_out[0] !== 1'b0 || aborted !== 4'b0001 || steps_left[31:0] !== 32'd9) begin
          errors++; $display("FAIL es_cut_stop: got step=%b aborted=%b left=%0d expected 0 0001 9",
                             step_out[0], aborted, steps_left[31:0]);
        end
        endstop_max = 4'b0000;
      end
    end
  endtask

  // ch0 -5: the max endstop is behind the motion and ignored; the min endstop blocks it.
  task automatic test_endstop_dir;
    logic prev;
    int   rises = 0;
    endstop_max = 4'b0001;
    issue(pack4(32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    prev = step_out[0];
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) @(negedge clk);
      if (step_out[0] && !prev) rises++;
      prev = step_out[0];
      if (k == 30) begin
        checks++; if (done !== 1'b1) begin
          errors++; $display("FAIL es_ign_done: got %b expected 1", done);
        end
      end
    end
    checks++; if (rises != 5 || aborted !== 4'b0000 || dir_out[0] !== 1'b1) begin
      errors++; $display("FAIL es_ign_run: got %0d pulses aborted=%b dir=%b expected 5 0000 1",
                         rises, aborted, dir_out[0]);
    end
    checks++; if (steps_left[31:0] !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL es_ign_end: got left=%h busy=%b expected 0 0",
                         steps_left[31:0], busy);
    end
    endstop_max = 4'b0000;
    endstop_min = 4'b0001;
    rises = 0;
    issue(pack4(32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (step_out[0]) rises++;
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin
          errors++; $display("FAIL es_min_busy: got %b expected 1", busy);
        end
      end
      if (k == 2) begin
        checks++;
        if (busy !== 1'b0 || aborted !== 4'b0001 || steps_left[31:0] !== 32'hFFFF_FFFB) begin
          errors++; $display("FAIL es_min_stop: got busy=%b aborted=%b left=%h expected 0 0001 fffffffb",
                             busy, aborted, steps_left[31:0]);
        end
      end
      if (k == 3) begin
        checks++; if (done !== 1'b1) begin
          errors++; $display("FAIL es_min_done: got %b expected 1", done);
        end
      end
    end
    checks++; if (rises != 0) begin
      errors++; $display("FAIL es_min_pulses: got %0d high cycles expected 0", rises);
    end
    endstop_min = 4'b0000;
  endtask

  // All-zero command and start-while-busy are both dropped.
  task automatic test_ignored;
    issue(128'd0, pack4(32'd2, 32'd2, 32'd2, 32'd2));
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || aborted !== 4'b0001 ||
          steps_left[31:0] !== 32'hFFFF_FFFB || dir_out !== 4'b0001) begin
        errors++; $display("FAIL zero_cmd k=%0d: got busy=%b done=%b aborted=%b left=%h dir=%b expected 0 0 0001 fffffffb 0001",
                           k, busy, done, aborted, steps_left[31:0], dir_out);
      end
    end
    issue(pack4(32'd3, 32'd0, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) @(negedge clk);
      checks++; if (step_out[3:1] !== 3'b000 || done !== (k == 22)) begin
        errors++; $display("FAIL busy_cmd k=%0d: got step=%b done=%b expected step[3:1]=000 done=%b",
                           k, step_out, done, (k == 22));
      end
      if (k == 7) begin
        checks++; if (steps_left[31:0] !== 32'd3 || steps_left[95:64] !== 32'd0) begin
          errors++; $display("FAIL busy_cmd_latch: got %h/%h expected 3/0",
                             steps_left[31:0], steps_left[95:64]);
        end
      end
      if (k == 5) begin
        steps_in  = pack4(32'd7, 32'd0, 32'd5, 32'd0);
        start     = 1'b1;
      end
      if (k == 6) start = 1'b0;
    end
    checks++; if (steps_left !== 128'd0 || dir_out !== 4'b0000 || aborted !== 4'b0000) begin
      errors++; $display("FAIL busy_cmd_end: got left=%h dir=%b aborted=%b expected 0 0000 0000",
                         steps_left, dir_out, aborted);
    end
  endtask

  // start and abort_all together while idle: start is taken, abort lands one cycle later.
  task automatic test_abort_race;
    @(negedge clk);
    steps_in  = pack4(32'd3, 32'hFFFF_FFFE, 32'd0, 32'd0);
    period_in = pack4(32'd2, 32'd2, 32'd2, 32'd2);
    start     = 1'b1;
    abort_all = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || aborted !== 4'b0000) begin
      errors++; $display("FAIL race_accept: got busy=%b aborted=%b expected 1 0000", busy, aborted);
    end
    @(negedge clk);
    abort_all = 1'b0;
    checks++; if (busy !== 1'b0 || aborted !== 4'b0011 || step_out !== 4'b0000) begin
      errors++; $display("FAIL race_abort: got busy=%b aborted=%b step=%b expected 0 0011 0000",
                         busy, aborted, step_out);
    end
    checks++; if (steps_left[63:0] !== {32'hFFFF_FFFE, 32'd3}) begin
      errors++; $display("FAIL race_left: got %h expected fffffffe00000003", steps_left[63:0]);
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin
      errors++; $display("FAIL race_done: got %b expected 1", done);
    end
  endtask

  // Reset mid-pulse, then the most negative count with P=0, stopped by abort_all.
  task automatic test_reset_mid;
    logic e0;
    issue(pack4(32'd3, 32'd0, 32'd0, 32'd0), pack4(32'd2, 32'd2, 32'd2, 32'd2));
    for (int k = 2; k <= 10; k++) @(negedge clk);
    checks++; if (step_out[0] !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got %b expected 1", step_out[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (step_out !== 4'b0 || busy !== 1'b0 || steps_left !== 128'd0) begin
      errors++; $display("FAIL rst_mid: got step=%b busy=%b left=%h expected 0000 0 0",
                         step_out, busy, steps_left);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(pack4(32'h8000_0000, 32'd0, 32'd0, 32'd0), 128'd0);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      e0 = (k >= 9 && k <= 14 && ((k - 9) % 2) == 0);
      checks++; if (step_out[0] !== e0 || (k <= 14 && dir_out[0] !== 1'b1)) begin
        errors++; $display("FAIL minneg_step k=%0d: got step=%b dir=%b expected %b 1",
                           k, step_out[0], dir_out[0], e0);
      end
      if (k == 9) begin
        checks++; if (steps_left[31:0] !== 32'h8000_0000) begin
          errors++; $display("FAIL minneg_left9: got %h expected 80000000", steps_left[31:0]);
        end
      end
      if (k == 10) begin
        checks++; if (steps_left[31:0] !== 32'h8000_0001) begin
          errors++; $display("FAIL minneg_left10: got %h expected 80000001", steps_left[31:0]);
        end
      end
      if (k == 15) begin
        abort_all = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 4'b0001 || steps_left[31:0] !== 32'h8000_0003) begin
          errors++; $display("FAIL minneg_abort: got busy=%b aborted=%b left=%h expected 0 0001 80000003",
                             busy, aborted, steps_left[31:0]);
        end
      end
      if (k == 16) begin
        checks++; if (done !== 1'b1) begin
          errors++; $display("FAIL minneg_done: got %b expected 1", done);
        end
      end
      if (k == 14) abort_all = 1'b1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_endstop_low;
    test_endstop_cut;
    test_endstop_dir;
    test_ignored;
    test_abort_race;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
